hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It decodes the instructions held in D, E and M and compares register operands using the Tuse/Tnew model. It also tracks the multi-cycle mult/div unit with an internal busy counter. From these it drives the freeze of F/D and the bubble-insert clear (`Eclr`) into the D→E pipeline register, which is the sole producer of that register's clear.

## Interface
Parameters:
- `MULT_CYC`, 5, busy cycles loaded for mult/multu.
- `DIV_CYC`, 10, busy cycles loaded for div/divu.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, **asynchronous, active-low**; clears the busy counter and the stall counter.
- `instrD` input 32: instruction in D stage.
- `instrE` input 32: instruction in E stage, the D→E register `instr` output.
- `waE` input 5: destination register of the E instruction.
- `instrM` input 32: instruction in M stage.
- `waM` input 5: destination register of the M instruction.
- `stall` output 1: hold PC and the F→D register for this cycle.
- `Eclr` output 1: clear the D→E register at the next edge (bubble).
- `md_busy` output 1: mult/div unit busy (started in E or counter nonzero).
- `stall_cnt` output 32: stall-cycle count (see Configuration).

## Operation
- Decoded subset:
  - Loads: lw, lh, lhu, lb, lbu.
  - Stores: sw, sh, sb.
  - Branch/jump-register: beq, bne, jr, jalr.
  - ALU R/I class.
  - mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
  - jal.
  - Other opcodes: no reads, no writes.
- Tuse of the D instruction:
  - beq/bne/jr/jalr: rs and rt = 0.
  - Store: rs = 1, rt = 2.
  - All other readers: 1 per read port.
- Tnew of the E instruction:
  - Load: 2.
  - ALU or mfhi/mflo: 1.
  - jal/jalr: 0.
  - Non-writer: none.
- Tnew of the M instruction:
  - Load: 1.
  - Otherwise: 0.
- Data stall condition, per D read port reg r ≠ 0:
  - (r == waE && TnewE > Tuse), or
  - (r == waM && TnewM > Tuse).
  - Register 0 never stalls.
- md start: instrE is mult/multu/div/divu.
- MD stall: instrD is any of the 8 md-class instructions while `md_busy`.
- Busy counter:
  - 4-bit `cnt`.
  - On each edge where md start holds, load MULT_CYC or DIV_CYC.
  - Else, if cnt ≠ 0, decrement by 1; 0 holds.
  - `md_busy` = md start | (cnt ≠ 0).
- `stall` = data stall | MD stall.
- `Eclr` = `stall`.
- `stall` and `Eclr` are combinational from the current inputs and `cnt`; there is no registered delay.

## Timing
- Reset (`rst` = 0, asynchronous):
  - Forces cnt = 0 and stall_cnt = 0 immediately.
  - Outputs then follow the input decode.
  - With the pipeline registers also reset to 0 (nop), stall = 0, Eclr = 0, md_busy = 0.
- Reset deasserting mid-count: the count is lost, and the next md-class instruction in D is not stalled.
- Load-use (lw in E, consumer in D with Tuse 1): stall = 1 for exactly 1 cycle. Next cycle the lw is in M with TnewM = 1 ≤ 1, so there is no stall.
- Load→branch (Tuse 0): 2 stall cycles.
- ALU→branch: 1 stall cycle.
- mult enters E at cycle t:
  - md_busy = 1 during cycle t.
  - cnt = 5 after edge t, counting down to 0 after edge t+5.
  - md_busy = 1 for cycles t..t+5 (6 cycles), 0 at t+6.
- A second md start while cnt ≠ 0 cannot occur, because MD stall blocks it in D.
- Data stall and MD stall in the same cycle: a single stall. The count is not double-counted.

## Configuration
- `STALL_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every rising edge where `stall` = 1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by `rst`.
- Not defined: no counter logic; `stall_cnt` tied to 32'h0.

## Test plan
- Reset with `rst` = 0 during cnt = 3 → cnt = 0 immediately; after release, mflo in D gives stall = 0.
- `lw $8,0($0)` in E (waE = 8), `addu $9,$8,$8` in D → stall = 1 and Eclr = 1 for 1 cycle, then 0; with STALL_CNT_EN, stall_cnt 0→1.
- `lw $8` in E, `beq $8,$0` in D → stall for 2 consecutive cycles, then release.
- `addu $0,$1,$2` in E, `beq $0,$0` in D → no stall (register 0 excluded).
- `div` enters E at cycle 0, `mflo` in D from cycle 1 → stall = 1 through cycle 10, released at cycle 11; md_busy falls at cycle 11.
- `sw $8,0($9)` in D with `addu $8` in E (TnewE = 1, Tuse rt = 2) → stall = 0; the same `addu` writing $9 (Tuse rs = 1) → stall = 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew data-hazard detection plus mult/div busy
// tracking for the five-stage MIPS pipeline. Drives the F/D freeze (stall)
// and the D->E bubble clear (Eclr).
// Optional feature macro: STALL_CNT_EN enables the saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [4:0]  waE,
  input  logic [31:0] instrM,
  input  logic [4:0]  waM,
  output logic        stall,
  output logic        Eclr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic [3:0] {
    CL_NONE,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JR,
    CL_JALR,
    CL_ALU_R,
    CL_ALU_I,
    CL_MULT,
    CL_DIV,
    CL_MF,
    CL_MT,
    CL_JAL
  } iclass_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_t c;
    c = CL_NONE;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b:                 c = CL_ALU_R;
          6'h08:                        c = CL_JR;
          6'h09:                        c = CL_JALR;
          6'h10, 6'h12:                 c = CL_MF;
          6'h11, 6'h13:                 c = CL_MT;
          6'h18, 6'h19:                 c = CL_MULT;
          6'h1a, 6'h1b:                 c = CL_DIV;
          default:                      c = CL_NONE;
        endcase
      end
      6'h03:                            c = CL_JAL;
      6'h04, 6'h05:                     c = CL_BRANCH;
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f:       c = CL_ALU_I;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = CL_LOAD;
      6'h28, 6'h29, 6'h2b:              c = CL_STORE;
      default:                          c = CL_NONE;
    endcase
    return c;
  endfunction

  iclass_t    cls_d, cls_e, cls_m;
  logic [4:0] rs_d, rt_d;
  logic       rd_rs, rd_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic       wr_e;
  logic [1:0] tnew_e, tnew_m;
  logic       haz_rs, haz_rt;
  logic       md_start, md_class_d;
  logic [3:0] cnt;

  // Immediate/offset/rd fields never take part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{instrD[15:6], instrE[25:6], instrM[25:6]};

  // Classify the three in-flight instructions.
  always_comb begin
    cls_d = classify(instrD[31:26], instrD[5:0]);
    cls_e = classify(instrE[31:26], instrE[5:0]);
    cls_m = classify(instrM[31:26], instrM[5:0]);
    rs_d  = instrD[25:21];
    rt_d  = instrD[20:16];
  end

  // Read ports and Tuse of the instruction in D.
  always_comb begin
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    tuse_rs = 2'd1;
    tuse_rt = 2'd1;
    case (cls_d)
      CL_BRANCH: begin
        rd_rs   = 1'b1;
        rd_rt   = 1'b1;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      CL_JR, CL_JALR: begin
        rd_rs   = 1'b1;
        tuse_rs = 2'd0;
      end
      CL_STORE: begin
        rd_rs   = 1'b1;
        rd_rt   = 1'b1;
        tuse_rt = 2'd2;
      end
      CL_LOAD, CL_ALU_I, CL_MT: rd_rs = 1'b1;
      CL_ALU_R, CL_MULT, CL_DIV: begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Tnew of the producers in E and M.
  always_comb begin
    wr_e   = 1'b0;
    tnew_e = 2'd0;
    case (cls_e)
      CL_LOAD: begin
        wr_e   = 1'b1;
        tnew_e = 2'd2;
      end
      CL_ALU_R, CL_ALU_I, CL_MF: begin
        wr_e   = 1'b1;
        tnew_e = 2'd1;
      end
      CL_JAL, CL_JALR: wr_e = 1'b1;
      default: ;
    endcase
    tnew_m = (cls_m == CL_LOAD) ? 2'd1 : 2'd0;
  end

  // Data hazards, mult/div hazards and the combined freeze/bubble request.
  always_comb begin
    haz_rs = rd_rs && (rs_d != '0) &&
             ((wr_e && (rs_d == waE) && (tnew_e > tuse_rs)) ||
              ((rs_d == waM) && (tnew_m > tuse_rs)));
    haz_rt = rd_rt && (rt_d != '0) &&
             ((wr_e && (rt_d == waE) && (tnew_e > tuse_rt)) ||
              ((rt_d == waM) && (tnew_m > tuse_rt)));
    md_start   = (cls_e == CL_MULT) || (cls_e == CL_DIV);
    md_class_d = (cls_d == CL_MULT) || (cls_d == CL_DIV) ||
                 (cls_d == CL_MF)   || (cls_d == CL_MT);
    md_busy    = md_start || (cnt != '0);
    stall      = haz_rs || haz_rt || (md_class_d && md_busy);
    Eclr       = stall;
  end

  // Mult/div busy counter: load on start, then count down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (md_start) begin
      cnt <= (cls_e == CL_DIV) ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, multi-cycle sequences
// and random stimulus against a mnemonic-table reference model.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instrD, instrE, instrM;
  logic [4:0]  waE, waM;
  logic        stall, Eclr, md_busy;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst(rst),
    .instrD(instrD), .instrE(instrE), .waE(waE),
    .instrM(instrM), .waM(waM),
    .stall(stall), .Eclr(Eclr), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: busy while cycle index <= busy_until.
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] exp_cnt = '0;

  // Property tables keyed by mnemonic.
  int tuse_rs_tab[string];
  int tuse_rt_tab[string];
  int tnew_tab[string];
  int md_len[string];
  bit md_set[string];

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] i_lw(int rt, int base);   return itype('h23, base, rt, 0); endfunction
  function automatic logic [31:0] i_sw(int rt, int base);   return itype('h2b, base, rt, 0); endfunction
  function automatic logic [31:0] i_addu(int rd, int rs, int rt); return rtype(rs, rt, rd, 'h21); endfunction
  function automatic logic [31:0] i_beq(int rs, int rt);    return itype('h04, rs, rt, 0); endfunction
  function automatic logic [31:0] i_jr(int rs);             return rtype(rs, 0, 0, 'h08); endfunction
  function automatic logic [31:0] i_mfhi(int rd);           return rtype(0, 0, rd, 'h10); endfunction
  function automatic logic [31:0] i_mflo(int rd);           return rtype(0, 0, rd, 'h12); endfunction
  function automatic logic [31:0] i_mthi(int rs);           return rtype(rs, 0, 0, 'h11); endfunction
  function automatic logic [31:0] i_mult(int rs, int rt);   return rtype(rs, rt, 0, 'h18); endfunction
  function automatic logic [31:0] i_div(int rs, int rt);    return rtype(rs, rt, 0, 'h1a); endfunction
  function automatic logic [31:0] i_jal();                  return {6'h03, 26'd0}; endfunction

  function automatic string mnem(logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h00: return "sll";   6'h02: return "srl";   6'h03: return "sra";
        6'h04: return "sllv";  6'h06: return "srlv";  6'h07: return "srav";
        6'h08: return "jr";    6'h09: return "jalr";
        6'h10: return "mfhi";  6'h11: return "mthi";  6'h12: return "mflo";
        6'h13: return "mtlo";  6'h18: return "mult";  6'h19: return "multu";
        6'h1a: return "div";   6'h1b: return "divu";
        6'h20: return "add";   6'h21: return "addu";  6'h22: return "sub";
        6'h23: return "subu";  6'h24: return "and";   6'h25: return "or";
        6'h26: return "xor";   6'h27: return "nor";   6'h2a: return "slt";
        6'h2b: return "sltu";
        default: return "none";
      endcase
    end
    case (op)
      6'h03: return "jal";   6'h04: return "beq";   6'h05: return "bne";
      6'h08: return "addi";  6'h09: return "addiu"; 6'h0a: return "slti";
      6'h0b: return "sltiu"; 6'h0c: return "andi";  6'h0d: return "ori";
      6'h0e: return "xori";  6'h0f: return "lui";
      6'h20: return "lb";    6'h21: return "lh";    6'h23: return "lw";
      6'h24: return "lbu";   6'h25: return "lhu";
      6'h28: return "sb";    6'h29: return "sh";    6'h2b: return "sw";
      default: return "none";
    endcase
  endfunction

  task automatic build_tables();
    string alu_r[$] = '{"sll","srl","sra","sllv","srlv","srav","add","addu",
                        "sub","subu","and","or","xor","nor","slt","sltu"};
    string alu_i[$] = '{"addi","addiu","slti","sltiu","andi","ori","xori","lui"};
    string lds[$]   = '{"lw","lh","lhu","lb","lbu"};
    string sts[$]   = '{"sw","sh","sb"};
    string mds[$]   = '{"mult","multu","div","divu","mfhi","mflo","mthi","mtlo"};
    foreach (alu_r[i]) begin tuse_rs_tab[alu_r[i]] = 1; tuse_rt_tab[alu_r[i]] = 1; tnew_tab[alu_r[i]] = 1; end
    foreach (alu_i[i]) begin tuse_rs_tab[alu_i[i]] = 1; tnew_tab[alu_i[i]] = 1; end
    foreach (lds[i])   begin tuse_rs_tab[lds[i]] = 1; tnew_tab[lds[i]] = 2; end
    foreach (sts[i])   begin tuse_rs_tab[sts[i]] = 1; tuse_rt_tab[sts[i]] = 2; end
    foreach (mds[i])   md_set[mds[i]] = 1'b1;
    tuse_rs_tab["beq"] = 0; tuse_rt_tab["beq"] = 0;
    tuse_rs_tab["bne"] = 0; tuse_rt_tab["bne"] = 0;
    tuse_rs_tab["jr"]  = 0;
    tuse_rs_tab["jalr"] = 0; tnew_tab["jalr"] = 0;
    tnew_tab["jal"] = 0;
    tnew_tab["mfhi"] = 1; tnew_tab["mflo"] = 1;
    tuse_rs_tab["mthi"] = 1; tuse_rs_tab["mtlo"] = 1;
    tuse_rs_tab["mult"] = 1; tuse_rt_tab["mult"] = 1;
    tuse_rs_tab["multu"] = 1; tuse_rt_tab["multu"] = 1;
    tuse_rs_tab["div"] = 1; tuse_rt_tab["div"] = 1;
    tuse_rs_tab["divu"] = 1; tuse_rt_tab["divu"] = 1;
    md_len["mult"] = 5; md_len["multu"] = 5;
    md_len["div"] = 10; md_len["divu"] = 10;
  endtask

  // Producer result age: Tnew drops by one per stage, floored at zero.
  task automatic model_eval(output bit s, output bit b);
    string md, me, mm;
    int te, tm, r, t;
    md = mnem(instrD);
    me = mnem(instrE);
    mm = mnem(instrM);
    te = tnew_tab.exists(me) ? tnew_tab[me] : -1;
    tm = (tnew_tab.exists(mm) && tnew_tab[mm] > 0) ? tnew_tab[mm] - 1 : 0;
    s = 1'b0;
    if (tuse_rs_tab.exists(md)) begin
      r = int'(instrD[25:21]);
      t = tuse_rs_tab[md];
      if (r != 0 && ((r == int'(waE) && te > t) || (r == int'(waM) && tm > t))) s = 1'b1;
    end
    if (tuse_rt_tab.exists(md)) begin
      r = int'(instrD[20:16]);
      t = tuse_rt_tab[md];
      if (r != 0 && ((r == int'(waE) && te > t) || (r == int'(waM) && tm > t))) s = 1'b1;
    end
    b = md_len.exists(me) || (cyc <= busy_until);
    if (md_set.exists(md) && b) s = 1'b1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic [31:0] d, logic [31:0] e, int we, logic [31:0] m, int wm);
    instrD = d;
    instrE = e;
    waE    = 5'(we);
    instrM = m;
    waM    = 5'(wm);
  endtask

  function automatic logic [31:0] cnt_expected();
`ifdef STALL_CNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  // One clock cycle: check on the falling edge, advance model on the rising edge.
  task automatic cycle(string tag, int want_st, int want_busy);
    bit s, b;
    string me;
    @(negedge clk);
    model_eval(s, b);
    chk({tag, " stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, " Eclr"}, {31'd0, Eclr}, {31'd0, s});
    chk({tag, " md_busy"}, {31'd0, md_busy}, {31'd0, b});
    chk({tag, " stall_cnt"}, stall_cnt, cnt_expected());
    if (want_st >= 0) chk({tag, " stall(directed)"}, {31'd0, stall}, 32'(want_st));
    if (want_busy >= 0) chk({tag, " md_busy(directed)"}, {31'd0, md_busy}, 32'(want_busy));
    me = mnem(instrE);
    @(posedge clk);
    if (md_len.exists(me)) busy_until = cyc + md_len[me];
    if (s && exp_cnt != '1) exp_cnt = exp_cnt + 32'd1;
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [31:0] e;
    int          wae;
    logic [31:0] m;
    int          wam;
    int          st;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(logic [31:0] d, logic [31:0] e, int wae, logic [31:0] m, int wam, int st);
    vec_t v;
    v.d = d; v.e = e; v.wae = wae; v.m = m; v.wam = wam; v.st = st;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt;
    rs = $urandom_range(0, 3);
    rt = $urandom_range(0, 3);
    case ($urandom_range(0, 15))
      0:  return i_addu($urandom_range(0, 3), rs, rt);
      1:  return i_lw(rt, rs);
      2:  return i_sw(rt, rs);
      3:  return i_beq(rs, rt);
      4:  return i_jr(rs);
      5:  return rtype(rs, 0, 31, 'h09);
      6:  return i_jal();
      7:  return itype('h0d, rs, rt, 5);
      8:  return i_mult(rs, rt);
      9:  return i_div(rs, rt);
      10: return i_mflo(rt);
      11: return i_mthi(rs);
      12: return itype('h21, rs, rt, 0);
      13: return itype('h05, rs, rt, 0);
      14: return {6'h02, 26'd4};
      default: return NOP;
    endcase
  endfunction

  initial begin
    build_tables();
    rst = 1'b0;
    set_in(NOP, NOP, 0, NOP, 0);
    #12;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset Eclr", {31'd0, Eclr}, 32'd0);
    chk("reset md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle vectors with an idle mult/div unit.
    add_vec(i_addu(9, 8, 8), i_lw(8, 0), 8, NOP, 0, 1);
    add_vec(i_sw(8, 9), i_addu(8, 1, 2), 8, NOP, 0, 0);
    add_vec(i_sw(8, 9), i_addu(9, 1, 2), 9, NOP, 0, 0);
    add_vec(i_beq(0, 0), i_addu(0, 1, 2), 0, NOP, 0, 0);
    add_vec(i_beq(8, 0), i_addu(8, 1, 2), 8, NOP, 0, 1);
    add_vec(i_sw(8, 9), i_lw(9, 0), 9, NOP, 0, 1);
    add_vec(i_sw(8, 9), i_lw(8, 0), 8, NOP, 0, 0);
    add_vec(i_addu(9, 8, 0), NOP, 0, i_lw(8, 0), 8, 0);
    add_vec(i_jr(8), NOP, 0, i_lw(8, 0), 8, 1);
    add_vec(i_jr(31), i_jal(), 31, NOP, 0, 0);
    add_vec(i_addu(1, 8, 0), i_mfhi(8), 8, NOP, 0, 0);
    add_vec(i_beq(8, 0), i_mfhi(8), 8, NOP, 0, 1);
    add_vec(i_mult(8, 8), i_lw(8, 0), 8, NOP, 0, 1);
    add_vec(i_mflo(1), NOP, 0, NOP, 0, 0);
    add_vec(i_beq(8, 0), i_sw(8, 0), 8, NOP, 0, 0);
    add_vec(i_beq(8, 0), i_mthi(8), 8, NOP, 0, 0);
    add_vec(i_beq(8, 0), NOP, 0, i_addu(8, 1, 2), 8, 0);
    add_vec(i_jr(0), i_lw(0, 0), 0, NOP, 0, 0);
    foreach (tbl[i]) begin
      set_in(tbl[i].d, tbl[i].e, tbl[i].wae, tbl[i].m, tbl[i].wam);
      cycle($sformatf("vec%0d", i), tbl[i].st, 0);
    end

    // Load-use: one bubble, then the load is in M and no longer blocks.
    set_in(i_addu(9, 8, 8), i_lw(8, 0), 8, NOP, 0);
    cycle("lduse c0", 1, 0);
    set_in(i_addu(9, 8, 8), NOP, 0, i_lw(8, 0), 8);
    cycle("lduse c1", 0, 0);

    // Load to branch: two bubbles.
    set_in(i_beq(8, 0), i_lw(8, 0), 8, NOP, 0);
    cycle("ldbr c0", 1, 0);
    set_in(i_beq(8, 0), NOP, 0, i_lw(8, 0), 8);
    cycle("ldbr c1", 1, 0);
    set_in(i_beq(8, 0), NOP, 0, NOP, 0);
    cycle("ldbr c2", 0, 0);

    // ALU to branch: one bubble.
    set_in(i_beq(8, 0), i_addu(8, 1, 2), 8, NOP, 0);
    cycle("alubr c0", 1, 0);
    set_in(i_beq(8, 0), NOP, 0, i_addu(8, 1, 2), 8);
    cycle("alubr c1", 0, 0);

    // div in E at cycle 0, mflo waits in D until cycle 11.
    set_in(NOP, i_div(1, 2), 0, NOP, 0);
    cycle("div c0", 0, 1);
    for (int k = 1; k <= 10; k++) begin
      set_in(i_mflo(3), NOP, 0, NOP, 0);
      cycle($sformatf("div c%0d", k), 1, 1);
    end
    set_in(i_mflo(3), NOP, 0, NOP, 0);
    cycle("div c11", 0, 0);

    // mult busy window: 6 cycles.
    set_in(NOP, i_mult(1, 2), 0, NOP, 0);
    cycle("mult c0", 0, 1);
    for (int k = 1; k <= 5; k++) begin
      set_in(NOP, NOP, 0, NOP, 0);
      cycle($sformatf("mult c%0d", k), 0, 1);
    end
    cycle("mult c6", 0, 0);

    // Asynchronous reset while the busy counter holds 3.
    set_in(NOP, i_mult(1, 2), 0, NOP, 0);
    cycle("rstmid c0", 0, 1);
    set_in(NOP, NOP, 0, NOP, 0);
    cycle("rstmid c1", 0, 1);
    cycle("rstmid c2", 0, 1);
    set_in(i_mflo(3), NOP, 0, NOP, 0);
    #2;
    chk("rstmid pre stall", {31'd0, stall}, 32'd1);
    chk("rstmid pre md_busy", {31'd0, md_busy}, 32'd1);
    rst = 1'b0;
    #1;
    busy_until = -1;
    exp_cnt = '0;
    chk("rstmid async md_busy", {31'd0, md_busy}, 32'd0);
    chk("rstmid async stall", {31'd0, stall}, 32'd0);
    chk("rstmid async stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("rstmid after", 0, 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      set_in(rand_instr(), rand_instr(), $urandom_range(0, 3), rand_instr(), $urandom_range(0, 3));
      cycle($sformatf("rand%0d", k), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
